// File: rtl/needle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : needle_scheduler
//  Purpose  : Shares one active-low needle (strobe) generator between N_REQ
//             trigger requesters. Rising edges on req are queued as pending
//             bits, granted round-robin, and each grant runs the sequence
//             DELAY -> PULSE (needle low) -> HOLD before the next grant.
//  Ports    :
//    clk         system clock, rising edge
//    reset_n     synchronous reset, active low
//    req         trigger lines (rising edge = request)
//    gate        enable; low blocks grants and forces needle high
//    delay       cycles from grant to first needle-low cycle
//    width       needle-low cycles (0 behaves as 1)
//    holdoff     needle-high idle cycles after a needle before next grant
//    missed_clr  clears the sticky missed flags
//    needle      registered needle, active low, idle high
//    grant_id    requester being / last served
//    busy        high whenever the sequencer is not IDLE
//    pending     queued requests
//    missed      sticky overflow flags
//  Revision : 1.0  initial release
// ============================================================================
module needle_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             gate,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] holdoff,
  input  logic             missed_clr,
  output logic             needle,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] missed
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state;
  logic [N_REQ-1:0] req_q;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width_lat;
  logic [CNT_W-1:0] holdoff_lat;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] serving;
  logic [N_REQ-1:0] overflow;
  logic [N_REQ-1:0] grant_mask;
  logic [N_REQ-1:0] pending_next;
  logic [N_REQ-1:0] missed_next;
  logic             do_grant;
  logic             found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  ptr_next;
  logic [CNT_W-1:0] width_eff;

  assign busy      = (state != IDLE);
  assign rise      = req & ~req_q;
  assign width_eff = (width == '0) ? CNT_W'(1) : width;

  // A requester counts as "being served" for the whole DELAY/PULSE/HOLD
  // sequence of its grant; a fresh edge then is an overflow, not a request.
  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
      assign serving[i]  = busy && (grant_id == ID_W'(i));
      assign overflow[i] = rise[i] && (pending[i] || serving[i]);
    end
  endgenerate

  // Round-robin search starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && pending[idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign do_grant   = (state == IDLE) && gate && found;
  assign ptr_next   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  assign grant_mask = do_grant ? (N_REQ'(1) << grant_idx) : '0;

  // Set beats clear: an edge on the granted index at the grant edge re-queues.
  assign pending_next = (pending & ~grant_mask) | (rise & ~serving);
  // Overflow beats missed_clr on the same edge.
  assign missed_next  = (missed & ~{N_REQ{missed_clr}}) | overflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_q       <= '0;
      ptr         <= '0;
      cnt         <= '0;
      width_lat   <= '0;
      holdoff_lat <= '0;
      grant_id    <= '0;
      pending     <= '0;
      missed      <= '0;
      needle      <= 1'b1;
    end else begin
      req_q   <= req;
      pending <= pending_next;
      missed  <= missed_next;
      // Needle follows the state one cycle later; gate masks it immediately.
      needle  <= ~((state == PULSE) && gate);

      case (state)
        IDLE: begin
          if (do_grant) begin
            grant_id    <= grant_idx;
            ptr         <= ptr_next;
            width_lat   <= width_eff;
            holdoff_lat <= holdoff;
            if (delay != '0) begin
              state <= DELAY;
              cnt   <= delay - CNT_W'(1);
            end else begin
              state <= PULSE;
              cnt   <= width_eff - CNT_W'(1);
            end
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            state <= PULSE;
            cnt   <= width_lat - CNT_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            if (holdoff_lat != '0) begin
              // HOLD spans holdoff+1 state cycles: its first cycle still
              // shows the final needle-low (register lag), leaving exactly
              // holdoff needle-high cycles before IDLE.
              state <= HOLD;
              cnt   <= holdoff_lat;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/needle_scheduler.md
Name: needle_scheduler

Overview:
- Synchronous controller that shares one needle (short active-low strobe) generator between N_REQ trigger requesters.
- Detects rising edges on the requester lines, queues them as pending bits and grants them round-robin.
- For each grant, waits a programmable delay, drives a programmable-width needle, then enforces a holdoff.
- Sits in the trc block between the trigger sources and the downstream needle consumers, replacing the asynchronous edge-to-pulse path with a clocked, gated, arbitrated one.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 8, width of the delay/width/holdoff counters and config inputs.
- ID_W, 2, width of grant_id (must satisfy 2**ID_W >= N_REQ).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous reset, active low.
- req  input  N_REQ  trigger lines, synchronous to clk; a rising edge is a request.
- gate  input  1  enable; low blocks new grants and forces needle high.
- delay  input  CNT_W  cycles between grant and first needle-low cycle.
- width  input  CNT_W  needle-low duration in cycles; 0 is treated as 1.
- holdoff  input  CNT_W  idle cycles after needle before the next grant.
- missed_clr  input  1  clears all missed bits.
- needle  output  1  registered, active low, idle high.
- grant_id  output  ID_W  index of the requester being served; holds its last value when idle.
- busy  output  1  high in any state other than IDLE.
- pending  output  N_REQ  queued requests.
- missed  output  N_REQ  sticky overflow flags.

Behaviour:
- Reset (reset_n low at a clk edge):
  - needle=1, busy=0, grant_id=0, pending=0, missed=0.
  - req_q=0, round-robin pointer=0, FSM state IDLE, all counters 0.
  - Reset mid-sequence aborts immediately; the needle returns high on that edge.
- Edge detect:
  - A rising edge at clock edge k means req[i]=1 with req_q[i]=0; req_q <= req on every edge.
  - On a rising edge at edge k, pending[i] is set at edge k.
- Overflow:
  - A rising edge on req[i] while pending[i]=1, or while i is currently being served, sets missed[i].
  - pending[i] stays set in that case and no second request is queued.
- missed_clr:
  - Clears missed at that edge.
  - If missed_clr is high and a new overflow occurs on the same edge, the overflow wins and the bit stays 1.
- Arbitration:
  - Happens only in IDLE with gate=1 and at least one pending bit.
  - Picks the first pending index starting at the pointer and wrapping modulo N_REQ.
  - On grant:
    - grant_id <= index.
    - pending[index] cleared.
    - pointer <= index+1, wrapping to 0 after N_REQ-1.
    - delay, width and holdoff latched into internal registers.
  - A new edge on the granted index arriving on the grant edge re-sets pending (set beats clear).
- FSM states and transitions:
  - IDLE -> DELAY on grant if latched delay>0; IDLE -> PULSE on grant if latched delay=0.
  - DELAY: counts latched delay cycles, then -> PULSE.
  - PULSE: needle low for max(width,1) cycles, then -> HOLD if holdoff>0, else -> IDLE.
  - HOLD: counts holdoff cycles, then -> IDLE.
- Latency: with req first high at edge k, gate=1, IDLE, no other pending:
  - The grant occurs at edge k+1.
  - needle is low during the cycles following edges k+2+D .. k+1+D+W, where D=delay and W=max(width,1).
  - busy goes high at edge k+1 and low at the edge that enters IDLE.
- needle is a register: needle <= ~(state==PULSE && gate), updated every edge.
- gate dropping mid-sequence:
  - The needle goes high on the next edge.
  - Timing counters keep running and the sequence completes silently.
  - Pending requests are held while gate=0.
- Config changes outside a grant edge have no effect on a sequence in progress.
- Back-to-back: with holdoff=0, the next grant can occur on the IDLE cycle right after the last PULSE cycle, giving a minimum of one needle-high cycle between needles.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles with req toggling -> needle=1, busy=0, pending=0, missed=0; after release and with no req edges, nothing changes for 20 cycles.
- Single request: delay=3, width=2, holdoff=4, gate=1; req[1] rises at edge k -> grant_id=1 at k+1; needle low exactly during cycles k+5 and k+6; busy low from edge k+11.
- Zero config: delay=0, width=0, holdoff=0; req[0] edge -> needle low for exactly 1 cycle starting after edge k+2; back in IDLE one cycle later.
- Round-robin: req[0..3] rise on the same edge with pointer=0 -> grant order 0,1,2,3, four distinct needles; then req[2] and req[0] together -> order 0,2.
- Overflow: req[2] pulses twice while pending[2]=1 -> missed[2]=1 and one needle only; missed_clr asserted alone -> missed=0; missed_clr coincident with a new overflow -> missed[2]=1.
- Gate and reset: gate=0 with req[3] edge -> no grant, pending[3]=1, needle=1; gate=1 -> normal needle. Gate dropped during PULSE -> needle high next edge while busy stays high through HOLD. reset_n=0 during DELAY -> IDLE with needle=1 next edge.
